// File: rtl/vga_text_writer.sv
// vga_text_writer
//   Turns CPU-side text commands into single-cycle writes on the write side
//   of the VGA controller's block-control array (one entry per character
//   cell, ROWS x COLS cells).
//
// Ports:
//   clk          clock
//   rst_n        asynchronous active-low reset
//   cmd_valid    command present
//   cmd_ready    command accepted this cycle if cmd_valid (state only)
//   cmd_op       0=PUTC, 1=SETCUR, 2=SETCOLOR, 3=CLEAR
//   cmd_data     command operand
//   vga_addr_v   write row
//   vga_addr_h   write column
//   vga_ctrl     control word {font[7:0], 15'b0, colour[8:0]}
//   vga_ctrl_en  one-cycle write strobe
//   busy         !cmd_ready
//   cursor_v     current cursor row
//   cursor_h     current cursor column
module vga_text_writer #(
  parameter int          ROWS     = 12,
  parameter int          COLS     = 32,
  parameter logic [7:0]  CLR_CHAR = 8'h20,
  parameter logic [8:0]  CLR_INIT = 9'h1FF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [15:0] cmd_data,
  output logic [3:0]  vga_addr_v,
  output logic [4:0]  vga_addr_h,
  output logic [31:0] vga_ctrl,
  output logic        vga_ctrl_en,
  output logic        busy,
  output logic [3:0]  cursor_v,
  output logic [4:0]  cursor_h
);

  localparam logic [1:0] OP_PUTC     = 2'd0;
  localparam logic [1:0] OP_SETCUR   = 2'd1;
  localparam logic [1:0] OP_SETCOLOR = 2'd2;
  localparam logic [1:0] OP_CLEAR    = 2'd3;

  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_CR = 8'h0D;

  localparam logic [3:0] LAST_ROW = 4'(ROWS - 1);
  localparam logic [4:0] LAST_COL = 5'(COLS - 1);
  localparam logic [8:0] N_CELLS  = 9'(ROWS * COLS);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t      state_q;
  logic [8:0]  cnt_q;        // index of the next cell to write during CLEAR
  logic [8:0]  colour_q;
  logic [3:0]  cursor_v_q;
  logic [4:0]  cursor_h_q;
  logic [3:0]  addr_v_q;
  logic [4:0]  addr_h_q;
  logic [31:0] ctrl_q;
  logic        ctrl_en_q;

  // Combinational helpers for the cursor and the clear-sweep address.
  logic [3:0]  row_inc_d;
  logic [3:0]  adv_v_d;
  logic [4:0]  adv_h_d;
  logic [3:0]  setcur_v_d;
  logic [3:0]  clr_v_d;
  logic [4:0]  clr_h_d;
  logic [7:0]  char_d;

  // Operand bits that carry no meaning for any command.
  logic        unused_data;
  assign unused_data = ^cmd_data[15:9];

  always_comb begin
    char_d     = cmd_data[7:0];
    // No scrolling: the row simply wraps back to the top.
    row_inc_d  = (cursor_v_q == LAST_ROW) ? 4'd0 : cursor_v_q + 4'd1;
    if (cursor_h_q == LAST_COL) begin
      adv_h_d = 5'd0;
      adv_v_d = row_inc_d;
    end else begin
      adv_h_d = cursor_h_q + 5'd1;
      adv_v_d = cursor_v_q;
    end
    setcur_v_d = (cmd_data[8:5] > LAST_ROW) ? LAST_ROW : cmd_data[8:5];
    clr_v_d    = 4'(cnt_q / 9'(COLS));
    clr_h_d    = 5'(cnt_q % 9'(COLS));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 9'd0;
      colour_q   <= CLR_INIT;
      cursor_v_q <= 4'd0;
      cursor_h_q <= 5'd0;
      addr_v_q   <= 4'd0;
      addr_h_q   <= 5'd0;
      ctrl_q     <= 32'd0;
      ctrl_en_q  <= 1'b0;
    end else begin
      ctrl_en_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            case (cmd_op)
              OP_PUTC: begin
                if (char_d == CH_LF) begin
                  cursor_h_q <= 5'd0;
                  cursor_v_q <= row_inc_d;
                end else if (char_d == CH_CR) begin
                  cursor_h_q <= 5'd0;
                end else begin
                  addr_v_q   <= cursor_v_q;
                  addr_h_q   <= cursor_h_q;
                  ctrl_q     <= {char_d, 15'd0, colour_q};
                  ctrl_en_q  <= 1'b1;
                  cursor_v_q <= adv_v_d;
                  cursor_h_q <= adv_h_d;
                end
              end
              OP_SETCUR: begin
                cursor_v_q <= setcur_v_d;
                cursor_h_q <= cmd_data[4:0];
              end
              OP_SETCOLOR: begin
                colour_q <= cmd_data[8:0];
              end
              default: begin  // OP_CLEAR
                // Cell 0 is written straight from the acceptance edge so the
                // sweep has no leading bubble. The control word latched here
                // (with the current colour) is held for the whole sweep.
                state_q   <= ST_CLEAR;
                addr_v_q  <= 4'd0;
                addr_h_q  <= 5'd0;
                ctrl_q    <= {CLR_CHAR, 15'd0, colour_q};
                ctrl_en_q <= 1'b1;
                cnt_q     <= 9'd1;
              end
            endcase
          end
        end
        default: begin  // ST_CLEAR
          if (cnt_q == N_CELLS) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 9'd0;
            cursor_v_q <= 4'd0;
            cursor_h_q <= 5'd0;
          end else begin
            addr_v_q  <= clr_v_d;
            addr_h_q  <= clr_h_d;
            ctrl_en_q <= 1'b1;
            cnt_q     <= cnt_q + 9'd1;
          end
        end
      endcase
    end
  end

  assign cmd_ready   = (state_q == ST_IDLE);
  assign busy        = ~cmd_ready;
  assign vga_addr_v  = addr_v_q;
  assign vga_addr_h  = addr_h_q;
  assign vga_ctrl    = ctrl_q;
  assign vga_ctrl_en = ctrl_en_q;
  assign cursor_v    = cursor_v_q;
  assign cursor_h    = cursor_h_q;

endmodule

// File: tb/tb_vga_text_writer.sv
// Self-checking bench for vga_text_writer: a command table with hand-derived
// cursor/write results, a write scoreboard, and sequences for CLEAR and
// reset during CLEAR.
module tb_vga_text_writer;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_data;
  logic [3:0]  vga_addr_v;
  logic [4:0]  vga_addr_h;
  logic [31:0] vga_ctrl;
  logic        vga_ctrl_en;
  logic        busy;
  logic [3:0]  cursor_v;
  logic [4:0]  cursor_h;

  vga_text_writer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_data    (cmd_data),
    .vga_addr_v  (vga_addr_v),
    .vga_addr_h  (vga_addr_h),
    .vga_ctrl    (vga_ctrl),
    .vga_ctrl_en (vga_ctrl_en),
    .busy        (busy),
    .cursor_v    (cursor_v),
    .cursor_h    (cursor_h)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  op;
    logic [15:0] data;
    logic        wr;
    logic [3:0]  wv;
    logic [4:0]  wh;
    logic [31:0] wdata;
    logic [3:0]  cv;
    logic [4:0]  ch;
  } vec_t;

  typedef struct packed {
    logic [3:0]  v;
    logic [4:0]  h;
    logic [31:0] d;
  } wr_t;

  int  total = 0;
  int  bad   = 0;
  int  strobe_cnt = 0;
  wr_t exp_q[$];
  vec_t vecs[18];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every strobe must match the oldest pending expected write.
  always @(negedge clk) begin
    wr_t e;
    if (vga_ctrl_en === 1'b1) begin
      strobe_cnt++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_strobe: got (%0d,%0d)=%h expected no write (t=%0t)",
                 vga_addr_v, vga_addr_h, vga_ctrl, $time);
      end else begin
        e = exp_q.pop_front();
        check("write", {23'd0, vga_addr_v, vga_addr_h, vga_ctrl}, {23'd0, e.v, e.h, e.d});
      end
    end
  end

  initial begin
    int n;
    int base;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    cmd_data  = 16'd0;

    //          op    data      wr  wv     wh     wdata          cv     ch
    vecs[0]  = '{2'd2, 16'h0038, 1'b0, 4'd0,  5'd0,  32'h0,         4'd0,  5'd0};
    vecs[1]  = '{2'd0, 16'h0041, 1'b1, 4'd0,  5'd0,  32'h4100_0038, 4'd0,  5'd1};
    vecs[2]  = '{2'd0, 16'h0042, 1'b1, 4'd0,  5'd1,  32'h4200_0038, 4'd0,  5'd2};
    vecs[3]  = '{2'd1, 16'h017F, 1'b0, 4'd0,  5'd0,  32'h0,         4'd11, 5'd31};
    vecs[4]  = '{2'd0, 16'h005A, 1'b1, 4'd11, 5'd31, 32'h5A00_0038, 4'd0,  5'd0};
    vecs[5]  = '{2'd1, 16'h01C3, 1'b0, 4'd0,  5'd0,  32'h0,         4'd11, 5'd3};
    vecs[6]  = '{2'd1, 16'h0067, 1'b0, 4'd0,  5'd0,  32'h0,         4'd3,  5'd7};
    vecs[7]  = '{2'd0, 16'h000D, 1'b0, 4'd0,  5'd0,  32'h0,         4'd3,  5'd0};
    vecs[8]  = '{2'd1, 16'h0165, 1'b0, 4'd0,  5'd0,  32'h0,         4'd11, 5'd5};
    vecs[9]  = '{2'd0, 16'h000A, 1'b0, 4'd0,  5'd0,  32'h0,         4'd0,  5'd0};
    vecs[10] = '{2'd0, 16'hAB30, 1'b1, 4'd0,  5'd0,  32'h3000_0038, 4'd0,  5'd1};
    vecs[11] = '{2'd2, 16'hFFC0, 1'b0, 4'd0,  5'd0,  32'h0,         4'd0,  5'd1};
    vecs[12] = '{2'd0, 16'h0043, 1'b1, 4'd0,  5'd1,  32'h4300_01C0, 4'd0,  5'd2};
    vecs[13] = '{2'd1, 16'h00BF, 1'b0, 4'd0,  5'd0,  32'h0,         4'd5,  5'd31};
    vecs[14] = '{2'd0, 16'h0044, 1'b1, 4'd5,  5'd31, 32'h4400_01C0, 4'd6,  5'd0};
    vecs[15] = '{2'd1, 16'h001F, 1'b0, 4'd0,  5'd0,  32'h0,         4'd0,  5'd31};
    vecs[16] = '{2'd0, 16'h000A, 1'b0, 4'd0,  5'd0,  32'h0,         4'd1,  5'd0};
    vecs[17] = '{2'd1, 16'hFE7F, 1'b0, 4'd0,  5'd0,  32'h0,         4'd3,  5'd31};

    #22 rst_n = 1'b1;

    // Reset state, sampled away from the clock edge.
    @(negedge clk);
    check("rst_ready",  {63'd0, cmd_ready},   64'd1);
    check("rst_busy",   {63'd0, busy},        64'd0);
    check("rst_en",     {63'd0, vga_ctrl_en}, 64'd0);
    check("rst_addr",   {55'd0, vga_addr_v, vga_addr_h}, 64'd0);
    check("rst_ctrl",   {32'd0, vga_ctrl},    64'd0);
    check("rst_cursor", {55'd0, cursor_v, cursor_h}, 64'd0);

    // Table: commands issued back-to-back, one per cycle.
    @(posedge clk); #1;
    for (int i = 0; i < 18; i++) begin
      if (vecs[i].wr) exp_q.push_back('{vecs[i].wv, vecs[i].wh, vecs[i].wdata});
      cmd_valid = 1'b1;
      cmd_op    = vecs[i].op;
      cmd_data  = vecs[i].data;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      $display("vec %0d op=%0d data=%h cursor=(%0d,%0d)", i, vecs[i].op, vecs[i].data, cursor_v, cursor_h);
      check("vec_cursor", {55'd0, cursor_v, cursor_h}, {55'd0, vecs[i].cv, vecs[i].ch});
    end
    repeat (3) @(posedge clk);
    #1;
    check("table_drained", 64'(exp_q.size()), 64'd0);

    // CLEAR with colour 9'h1C0, with a PUTC held valid across the sweep.
    for (int k = 0; k < 384; k++) exp_q.push_back('{4'(k / 32), 5'(k % 32), 32'h2000_01C0});
    cmd_valid = 1'b1;
    cmd_op    = 2'd3;
    cmd_data  = 16'h0000;
    @(posedge clk); #1;
    cmd_op   = 2'd0;
    cmd_data = 16'h0055;
    check("clear_busy", {63'd0, busy}, 64'd1);
    n = 0;
    while (cmd_ready !== 1'b1 && n < 500) begin
      n++;
      @(posedge clk); #1;
    end
    $display("clear: not-ready cycles=%0d", n);
    check("clear_len", 64'(n), 64'd384);
    check("clear_cursor", {55'd0, cursor_v, cursor_h}, 64'd0);
    check("clear_drained", 64'(exp_q.size()), 64'd0);
    exp_q.push_back('{4'd0, 5'd0, 32'h5500_01C0});
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("post_clear_cursor", {55'd0, cursor_v, cursor_h}, {55'd0, 4'd0, 5'd1});
    repeat (2) @(posedge clk);
    #1;

    // Reset in the middle of a CLEAR sweep, right after strobe 100.
    base = strobe_cnt + exp_q.size();
    for (int k = 0; k < 100; k++) exp_q.push_back('{4'(k / 32), 5'(k % 32), 32'h2000_01C0});
    cmd_valid = 1'b1;
    cmd_op    = 2'd3;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    n = 0;
    while (strobe_cnt < base + 100 && n < 500) begin
      n++;
      @(negedge clk); #1;
    end
    check("mid_clear_reached", {63'd0, (strobe_cnt == base + 100)}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_en",     {63'd0, vga_ctrl_en}, 64'd0);
    check("midrst_ready",  {63'd0, cmd_ready},   64'd1);
    check("midrst_busy",   {63'd0, busy},        64'd0);
    check("midrst_ctrl",   {32'd0, vga_ctrl},    64'd0);
    check("midrst_cursor", {55'd0, cursor_v, cursor_h}, 64'd0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check("after_rst_ready", {63'd0, cmd_ready}, 64'd1);
    // Colour must be back at its reset value (white).
    exp_q.push_back('{4'd0, 5'd0, 32'h6100_01FF});
    cmd_valid = 1'b1;
    cmd_op    = 2'd0;
    cmd_data  = 16'h0061;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("after_rst_cursor", {55'd0, cursor_v, cursor_h}, {55'd0, 4'd0, 5'd1});
    repeat (3) @(posedge clk);
    #1;
    check("final_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_text_writer.md
# vga_text_writer

Command-driven writer for the VGA character-block control memory. It turns CPU-side text commands into single-cycle block-control writes, with one write per 12 x 32 character cell. Commands are put-character, set-cursor, set-colour and clear-screen. It sits between the bus register slave and the VGA controller. It owns the write side (row address, column address, control word, write enable) of the controller's block-control array.

## Interface
- ROWS, 12, character rows; row index 0..ROWS-1, 4-bit.
- COLS, 32, character columns; column index 0..COLS-1, 5-bit.
- CLR_CHAR, 8'h20, font code written by clear-screen.
- CLR_INIT, 9'h1FF, colour register reset value (white).

Reset and clock: reset rst_n, asynchronous, active-low; clock clk.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command this cycle
- cmd_op  in  2  0=PUTC, 1=SETCUR, 2=SETCOLOR, 3=CLEAR
- cmd_data  in  16  command operand
- vga_addr_v  out  4  write row
- vga_addr_h  out  5  write column
- vga_ctrl  out  32  control word: [31:24] font code, [8:0] colour, all other bits 0
- vga_ctrl_en  out  1  one-cycle write strobe
- busy  out  1  equals !cmd_ready
- cursor_v  out  4  current cursor row
- cursor_h  out  5  current cursor column

## Operation
- **Handshake:** a command is accepted on a rising edge with cmd_valid && cmd_ready. cmd_ready depends only on state, never on cmd_valid.
- **States:** IDLE (cmd_ready=1) and CLEAR (cmd_ready=0).
- **PUTC, cmd_data[7:0]=c:**
  - c=8'h0A (LF): no write; cursor_h=0; cursor_v advances.
  - c=8'h0D (CR): no write; cursor_h=0.
  - Any other c: write {c, 15'b0, colour} to (cursor_v, cursor_h), then advance the cursor.
- **Cursor advance:** h+1. When h=COLS-1, h=0 and v advances.
- **Row advance:** v+1. When v=ROWS-1, v wraps to 0. There is no scrolling.
- **SETCUR:** v=cmd_data[8:5], h=cmd_data[4:0]. A v value of ROWS or higher is clamped to ROWS-1. No write.
- **SETCOLOR:** colour register = cmd_data[8:0]. It applies to subsequent PUTC. No write.
- **CLEAR:**
  - Latch the current colour and enter CLEAR.
  - Emit ROWS*COLS writes of {CLR_CHAR, 15'b0, latched colour} in row-major order: (0,0), (0,1) .. (0,31), (1,0) .. (11,31).
  - The cell counter is 9-bit, split into v=cnt/COLS and h=cnt%COLS.
  - After the last write, cursor=(0,0) and the state returns to IDLE.
- **Unused bits:** cmd_data bits not named above are ignored.
- **Reset:** rst_n low at any time, including mid-CLEAR, aborts the operation immediately. No further writes are emitted.

## Timing
- **Reset values:** cmd_ready=1, busy=0, vga_ctrl_en=0, vga_addr_v=0, vga_addr_h=0, vga_ctrl=0, cursor=(0,0), colour=CLR_INIT.
- **Registered outputs:** all write-port outputs are registered. A PUTC accepted at edge t drives vga_ctrl_en=1 with address and data during cycle t+1, for exactly one cycle.
- **Cursor update:** the cursor updates at the acceptance edge, so cursor_v and cursor_h show the new position in cycle t+1.
- **Back-to-back PUTC:** one write per cycle, no bubbles. The second PUTC uses the cursor already advanced by the first.
- **PUTC after SETCOLOR/SETCUR:** when PUTC is accepted the cycle after SETCOLOR or SETCUR, it uses the new value.
- **CLEAR accepted at edge t:**
  - cmd_ready=0 and busy=1 in cycles t+1 .. t+384.
  - vga_ctrl_en=1 in cycles t+1 .. t+384.
  - Cycle t+384 carries address (11,31).
  - Cursor=(0,0) and cmd_ready=1 from cycle t+385.
- **No simultaneous commands:** commands are never accepted while in CLEAR, so simultaneous command/clear cannot occur.
- **vga_ctrl outside writes:** vga_ctrl holds its last value when vga_ctrl_en=0.
- **Throughput:** one command per cycle in IDLE.

## Test plan
- **Reset:** rst_n pulse, then idle → all outputs at reset values, cmd_ready=1, colour 9'h1FF.
- **PUTC sequence:** SETCOLOR 9'h038; PUTC 8'h41, 8'h42 back-to-back → writes (0,0)=32'h4100_0038 and (0,1)=32'h4200_0038 on consecutive cycles; cursor=(0,2).
- **Wrap:** SETCUR v=11,h=31; PUTC 8'h5A → write (11,31), cursor wraps to (0,0). Then SETCUR v=14 → cursor_v=11.
- **Control characters:** SETCUR (3,7); PUTC 8'h0D → cursor (3,0), no strobe. PUTC 8'h0A at row 11 → cursor (0,0), no strobe.
- **CLEAR:** CLEAR with colour 9'h1C0 → exactly 384 strobes, row-major order, data 32'h2000_01C0, cmd_ready low for 384 cycles, cursor (0,0). cmd_valid held high during CLEAR is not accepted until t+385.
- **Reset mid-CLEAR:** assert rst_n low at strobe 100 → strobes stop immediately; after release cmd_ready=1 and a new PUTC writes at (0,0).
